// File: rtl/seg8_pkg.sv
// Shared constants for the 8-digit 7-segment scanner: segment bit positions,
// hex glyph table, display record type and the leading-zero blank-mask helper.
package seg8_pkg;

  localparam int NUM_DIGITS = 8;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [7:0] LEDS_OFF = 8'hFF;

  // Active-high glyphs, bit order g..a.
  localparam logic [6:0] HEX7_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  dp;
  } disp_t;

  // A digit is blanked when it and every digit above it are zero; digit 0 never blanks.
  function automatic logic [7:0] lzb_mask(input logic [31:0] value);
    logic [7:0] mask;
    logic       higher_zero;
    mask        = '0;
    higher_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      higher_zero = higher_zero && (value[4*k +: 4] == 4'h0);
      mask[k]     = higher_zero;
    end
    return mask;
  endfunction

endpackage

// File: rtl/seg8_scan_if.sv
// Load handshake between the value source (master) and the scanner (slave).
interface seg8_scan_if;
  logic        LOAD;
  logic [31:0] data;
  logic [7:0]  dp;
  logic        READY;

  modport master (output LOAD, output data, output dp, input READY);
  modport slave  (input LOAD, input data, input dp, output READY);
endinterface

// File: rtl/seg8_scan_hex7seg.sv
// Combinational nibble to active-high 7-segment glyph encoder.
module hex7seg
  import seg8_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  assign seg = HEX7_TABLE[nibble];
endmodule

// File: rtl/seg8_scan.sv
// Multiplexed 8-digit 7-segment scanner with frame-aligned commit and per-slot PWM.
// Optional leading-zero blanking is enabled by defining SEG8_LZB_EN.
module seg8_scan
  import seg8_pkg::*;
#(
  parameter int DIGIT_TICKS = 65536,
  parameter int PWM_BITS    = 4
) (
  input  logic                CLK,
  input  logic                RESET_N,
  seg8_scan_if.slave          bus,
  input  logic [PWM_BITS-1:0] BRIGHT,
  output logic                FRAME,
  output logic [7:0]          drains,
  output logic [7:0]          leds
);

  localparam int TICK_W              = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
  localparam int PHASE_DIV           = DIGIT_TICKS >> PWM_BITS;
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(DIGIT_TICKS - 1);

  logic [TICK_W-1:0] tick_q, tick_d;
  logic [2:0]        digit_q, digit_d;
  disp_t             shadow_q, shadow_d;
  disp_t             display_q, display_d;
  logic              pending_q, pending_d;
  logic              frame_q, frame_d;
  logic [7:0]        drains_q, drains_d;
  logic [7:0]        leds_q, leds_d;

  logic              tick_wrap, frame_wrap, accept, commit, lit;
  logic [TICK_W-1:0] phase_full;
  logic [3:0]        nibble;
  logic [6:0]        seg;

  assign nibble = display_q.data[{digit_q, 2'b00} +: 4];

  hex7seg u_hex7seg (
    .nibble (nibble),
    .seg    (seg)
  );

`ifdef SEG8_LZB_EN
  logic [7:0] blank_q, blank_d;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    tick_wrap  = (tick_q == TICK_MAX);
    frame_wrap = tick_wrap && (digit_q == 3'(NUM_DIGITS - 1));
    accept     = bus.LOAD && !pending_q;
    commit     = frame_wrap && pending_q;

    tick_d    = tick_wrap ? '0 : tick_q + 1'b1;
    digit_d   = tick_wrap ? digit_q + 3'd1 : digit_q;
    frame_d   = frame_wrap;
    shadow_d  = accept ? disp_t'{data: bus.data, dp: bus.dp} : shadow_q;
    display_d = commit ? shadow_q : display_q;

    // Accept and commit are exclusive: accept needs pending clear, commit needs it set.
    pending_d = pending_q;
    if (commit)      pending_d = 1'b0;
    else if (accept) pending_d = 1'b1;

    phase_full = tick_q / TICK_W'(PHASE_DIV);
    lit        = (phase_full[PWM_BITS-1:0] <= BRIGHT);
`ifdef SEG8_LZB_EN
    blank_d = commit ? lzb_mask(shadow_q.data) : blank_q;
    lit     = lit && !blank_q[digit_q];
`endif

    drains_d = '0;
    leds_d   = LEDS_OFF;
    if (lit) begin
      drains_d              = 8'b1 << digit_q;
      leds_d[SEG_DP]        = ~display_q.dp[digit_q];
      leds_d[SEG_G:SEG_A]   = ~seg;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      // NOTE: sequential state uses non-blocking assignments only, so all flops see pre-edge values.
      tick_q    <= '0;
      digit_q   <= '0;
      shadow_q  <= '0;
      display_q <= '0;
      pending_q <= 1'b0;
      frame_q   <= 1'b0;
      drains_q  <= '0;
      leds_q    <= LEDS_OFF;
`ifdef SEG8_LZB_EN
      blank_q   <= lzb_mask(32'h0);
`endif
    end else begin
      tick_q    <= tick_d;
      digit_q   <= digit_d;
      shadow_q  <= shadow_d;
      display_q <= display_d;
      pending_q <= pending_d;
      frame_q   <= frame_d;
      drains_q  <= drains_d;
      leds_q    <= leds_d;
`ifdef SEG8_LZB_EN
      blank_q   <= blank_d;
`endif
    end
  end

  assign bus.READY = ~pending_q;
  assign FRAME     = frame_q;
  assign drains    = drains_q;
  assign leds      = leds_q;

endmodule

// File: tb/tb_seg8_scan.sv
// Directed bench for seg8_scan with 16 clocks per digit slot and 4-bit PWM.
module tb_seg8_scan;

  localparam int DT = 16;
  localparam int PB = 4;
  localparam int FRAME_LEN = 8 * DT;
`ifdef SEG8_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic          CLK;
  logic          RESET_N;
  logic [PB-1:0] BRIGHT;
  logic          FRAME;
  logic [7:0]    drains;
  logic [7:0]    leds;

  seg8_scan_if bus ();

  seg8_scan #(.DIGIT_TICKS(DT), .PWM_BITS(PB)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus),
    .BRIGHT  (BRIGHT),
    .FRAME   (FRAME),
    .drains  (drains),
    .leds    (leds)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int         tests = 0;
  int         fails = 0;
  logic [7:0] seen_leds [8];
  int         lit_cnt   [8];
  int         scan_bad;
  int         frame_cnt;
  int         frame_last;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Steps until FRAME is seen, bounded; n is the number of steps taken.
  task automatic wait_frame(output int n);
    n = 0;
    for (int i = 0; i < 3 * FRAME_LEN; i++) begin
      step();
      n++;
      if (FRAME) break;
    end
    check("frame_seen", {31'd0, FRAME}, 32'd1);
  endtask

  // Observes one full frame starting right after a FRAME sample.
  task automatic scan_frame();
    int d;
    scan_bad   = 0;
    frame_cnt  = 0;
    frame_last = -1;
    for (int k = 0; k < 8; k++) begin
      seen_leds[k] = 8'hFF;
      lit_cnt[k]   = 0;
    end
    for (int c = 0; c < FRAME_LEN; c++) begin
      step();
      if (FRAME) begin
        frame_cnt++;
        frame_last = c;
      end
      if (drains != 8'h00) begin
        if (!$onehot(drains)) scan_bad++;
        d = 0;
        for (int k = 0; k < 8; k++) if (drains[k]) d = k;
        if (lit_cnt[d] == 0) seen_leds[d] = leds;
        else if (seen_leds[d] != leds) scan_bad++;
        lit_cnt[d]++;
      end else if (leds != 8'hFF) begin
        scan_bad++;
      end
    end
  endtask

  task automatic load(input logic [31:0] value, input logic [7:0] dpv);
    bus.LOAD = 1'b1;
    bus.data = value;
    bus.dp   = dpv;
    step();
    bus.LOAD = 1'b0;
  endtask

  initial begin
    int n;
    int old_bad;

    RESET_N  = 1'b0;
    BRIGHT   = '1;
    bus.LOAD = 1'b0;
    bus.data = '0;
    bus.dp   = '0;

    repeat (3) begin
      step();
      check("rst_drains", drains, 8'h00);
      check("rst_leds", leds, 8'hFF);
      check("rst_ready", bus.READY, 1);
    end

    RESET_N = 1'b1;
    check("rel_drains", drains, 8'h00);
    step();
    check("first_drains", drains, 8'h01);
    check("first_leds", leds, 8'hC0);
    check("first_ready", bus.READY, 1);
    wait_frame(n);
    check("first_frame_dist", n, FRAME_LEN - 1);

    scan_frame();
    check("frame_count", frame_cnt, 1);
    check("frame_period", frame_last, FRAME_LEN - 1);
    check("zero_d0", seen_leds[0], 8'hC0);
    check("zero_d0_cnt", lit_cnt[0], DT);
    check("zero_d7", seen_leds[7], LZB ? 8'hFF : 8'hC0);
    check("zero_scan", scan_bad, 0);

    // Mid-frame load, then a second load while busy that must be dropped.
    repeat (40) step();
    check("pre_load_ready", bus.READY, 1);
    load(32'h89ABCDEF, 8'h00);
    check("ready_fall", bus.READY, 0);
    repeat (5) step();
    load(32'h11111111, 8'hFF);
    check("ready_still_low", bus.READY, 0);
    old_bad = 0;
    for (int i = 0; i < 2 * FRAME_LEN; i++) begin
      step();
      if (drains != 8'h00 && leds != 8'hC0) old_bad++;
      if (FRAME) break;
      if (bus.READY !== 1'b0) old_bad++;
    end
    check("old_value_held", old_bad, 0);
    check("commit_frame", FRAME, 1);
    check("ready_rise", bus.READY, 1);

    scan_frame();
    check("new_d0", seen_leds[0], 8'h8E);
    check("new_d1", seen_leds[1], 8'h86);
    check("new_d3", seen_leds[3], 8'hC6);
    check("new_d7", seen_leds[7], 8'h80);
    check("new_d7_cnt", lit_cnt[7], DT);
    check("new_scan", scan_bad, 0);

    // PWM duty with BRIGHT sampled live at the frame boundary.
    BRIGHT = 4'd3;
    scan_frame();
    for (int d = 0; d < 8; d++) check($sformatf("pwm3_d%0d", d), lit_cnt[d], 4);
    check("pwm3_d5_leds", seen_leds[5], 8'h88);
    BRIGHT = 4'd0;
    scan_frame();
    check("pwm0_d0", lit_cnt[0], 1);
    check("pwm0_d7", lit_cnt[7], 1);
    check("pwm0_scan", scan_bad, 0);
    BRIGHT = '1;

    // Small value: leading zeros blank only when the option is built in.
    load(32'h00000012, 8'h00);
    wait_frame(n);
    scan_frame();
    check("v12_d0", seen_leds[0], 8'hA4);
    check("v12_d1", seen_leds[1], 8'hF9);
    check("v12_d2", seen_leds[2], LZB ? 8'hFF : 8'hC0);
    check("v12_d2_cnt", lit_cnt[2], LZB ? 0 : DT);
    check("v12_d7_cnt", lit_cnt[7], LZB ? 0 : DT);

    // Zero value with a dp on digit 7: dp must not unblank it.
    load(32'h00000000, 8'h80);
    wait_frame(n);
    scan_frame();
    check("v0_d0", seen_leds[0], 8'hC0);
    check("v0_d1_cnt", lit_cnt[1], LZB ? 0 : DT);
    check("v0_d7", seen_leds[7], LZB ? 8'hFF : 8'h40);
    check("v0_scan", scan_bad, 0);

    // Reset while a value is pending discards it.
    repeat (20) step();
    load(32'h89ABCDEF, 8'h00);
    check("rp_pending", bus.READY, 0);
    repeat (10) step();
    RESET_N = 1'b0;
    step();
    check("rp_ready", bus.READY, 1);
    check("rp_drains", drains, 8'h00);
    check("rp_leds", leds, 8'hFF);
    RESET_N = 1'b1;
    wait_frame(n);
    scan_frame();
    check("rp_d0", seen_leds[0], 8'hC0);
    check("rp_d1", seen_leds[1], LZB ? 8'hFF : 8'hC0);
    check("rp_d7", seen_leds[7], LZB ? 8'hFF : 8'hC0);
    check("rp_ready_after", bus.READY, 1);
    check("rp_scan", scan_bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
